// File: rtl/cpu_sram_bridge.sv
// Bridges the core's split instruction/data SRAM ports onto one shared
// request/addr_ok/data_ok memory bus. It serves at most two accesses per
// pipeline step, one at a time, and stalls the core until they are done.
module cpu_sram_bridge #(
    parameter bit DATA_FIRST = 1'b1,
    parameter bit KSEG_MAP   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_rvalid,
    output logic        stallreq,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        A_ADDR = 3'd1,
        A_WAIT = 3'd2,
        B_ADDR = 3'd3,
        B_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state;
    logic            inst_v;
    logic            data_v;
    logic            a_is_data;
    logic [AW-1:0]   inst_pa;
    logic [AW-1:0]   data_pa;
    logic            wr_q;
    logic [SW-1:0]   wstrb_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   inst_buf;
    logic [DW-1:0]   data_buf;

    logic            first_is_data;
    logic            cur_is_data;

    // Fold kseg0/kseg1 onto physical memory by clearing the segment bits.
    function automatic logic [AW-1:0] phys(input logic [AW-1:0] va);
        if (KSEG_MAP && (va[31:29] == 3'b100 || va[31:29] == 3'b101))
            return {3'b000, va[28:0]};
        return va;
    endfunction

    // Slot ordering: which access goes first, and which one is on the bus now.
    always_comb begin
        first_is_data = data_req & (DATA_FIRST | ~inst_req);
        cur_is_data   = (state == B_ADDR || state == B_WAIT) ? ~a_is_data : a_is_data;
    end

    // Freeze the core from the moment a request is seen until DONE.
    assign stallreq = resetn &
                      (((state == IDLE) & (inst_req | data_req)) |
                       (state == A_ADDR) | (state == A_WAIT) |
                       (state == B_ADDR) | (state == B_WAIT));

    // Sequencer: capture, issue slot A then optional slot B, report in DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            inst_v      <= 1'b0;
            data_v      <= 1'b0;
            a_is_data   <= 1'b0;
            inst_pa     <= '0;
            data_pa     <= '0;
            wr_q        <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            inst_buf    <= '0;
            data_buf    <= '0;
            inst_rdata  <= '0;
            data_rdata  <= '0;
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            bus_req     <= 1'b0;
            bus_wr      <= 1'b0;
            bus_wstrb   <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_req | data_req) begin
                        inst_v    <= inst_req;
                        data_v    <= data_req;
                        a_is_data <= first_is_data;
                        inst_pa   <= phys(inst_addr);
                        data_pa   <= phys(data_addr);
                        wr_q      <= data_wr;
                        wstrb_q   <= data_wstrb;
                        wdata_q   <= data_wdata;
                        bus_req   <= 1'b1;
                        bus_addr  <= first_is_data ? phys(data_addr) : phys(inst_addr);
                        bus_wr    <= first_is_data & data_wr;
                        bus_wstrb <= first_is_data ? data_wstrb : 4'hF;
                        bus_wdata <= first_is_data ? data_wdata : '0;
                        state     <= A_ADDR;
                    end
                end
                A_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= A_WAIT;
                    end
                end
                B_ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= B_WAIT;
                    end
                end
                A_WAIT, B_WAIT: begin
                    if (bus_data_ok) begin
                        if (cur_is_data) begin
                            if (!wr_q) data_buf <= bus_rdata;
                        end else begin
                            inst_buf <= bus_rdata;
                        end
                        if (state == A_WAIT && inst_v && data_v) begin
                            bus_req   <= 1'b1;
                            bus_addr  <= a_is_data ? inst_pa : data_pa;
                            bus_wr    <= ~a_is_data & wr_q;
                            bus_wstrb <= a_is_data ? 4'hF : wstrb_q;
                            bus_wdata <= a_is_data ? '0 : wdata_q;
                            state     <= B_ADDR;
                        end else begin
                            inst_rvalid <= inst_v;
                            data_rvalid <= data_v;
                            inst_rdata  <= cur_is_data ? inst_buf : bus_rdata;
                            data_rdata  <= (cur_is_data && !wr_q) ? bus_rdata : data_buf;
                            state       <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_sram_bridge.md
Name: cpu_sram_bridge

Overview:
- Sits directly downstream of the CPU core's split instruction/data SRAM ports and feeds the single shared memory bus.
- Accepts one instruction fetch and/or one data access per pipeline step.
- Serialises them onto one request/addr_ok/data_ok bus and returns the read data.
- Holds the core through a stall request until every access of the step has completed; this lets the core run against real, variable-latency memory.

Parameters:
- DATA_FIRST, 1, 1 = serve the data access before the fetch when both are present; 0 = fetch first.
- KSEG_MAP, 1, 1 = addresses with bits[31:29] equal to 3'b100 or 3'b101 have bits[31:29] cleared before going out on the bus; 0 = addresses pass through unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- inst_req  in  1  core wants a fetch this step.
- inst_addr  in  32  fetch virtual address.
- inst_rdata  out  32  fetched word.
- inst_rvalid  out  1  one-cycle pulse: inst_rdata valid.
- data_req  in  1  core wants a data access this step.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte enables for the access.
- data_addr  in  32  data virtual address.
- data_wdata  in  32  store data.
- data_rdata  out  32  load data.
- data_rvalid  out  1  one-cycle pulse: data access complete; data_rdata valid on reads.
- stallreq  out  1  freeze request to ctrl.
- bus_req  out  1  bus request.
- bus_wr  out  1  bus write.
- bus_wstrb  out  4  bus byte enables.
- bus_addr  out  32  physical address.
- bus_wdata  out  32  bus write data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  response / write done.
- bus_rdata  in  32  read response data.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - All outputs 0.
  - Captured request registers and result buffers cleared.
  - A bus_data_ok arriving after a mid-transaction reset is ignored, because state is no longer a WAIT state.
- States:
  - IDLE, A_ADDR, A_WAIT, B_ADDR, B_WAIT, DONE.
  - Slot A holds the first-served access and slot B the second, ordered by DATA_FIRST.
  - When only one access is present, slot A holds it and B is skipped.
- IDLE:
  - If inst_req|data_req, capture both requests in full (the address after KSEG_MAP, data_wr, data_wstrb, data_wdata).
  - Next state is A_ADDR.
  - Otherwise remain in IDLE.
- A_ADDR / B_ADDR:
  - bus_req=1 and the bus_* fields are driven from the captured slot.
  - On bus_req & bus_addr_ok, move to the matching WAIT state; bus_req deasserts on the following cycle.
- A_WAIT / B_WAIT:
  - bus_data_ok is sampled only in these states.
  - On bus_data_ok, latch bus_rdata into the slot buffer (latched for reads only).
  - Next state: B_ADDR if slot B is pending, else DONE.
  - bus_data_ok is never sampled in an ADDR state; the bus guarantees at least one cycle between addr_ok and data_ok.
- DONE (exactly one cycle):
  - inst_rvalid/data_rvalid pulse only for the accesses that were requested.
  - *_rdata hold the buffered words and stay stable until the next DONE.
  - Next state is IDLE.
- inst fetches always use bus_wr=0 and bus_wstrb=4'hF.
- stallreq (combinational):
  - 1 when (state==IDLE and (inst_req|data_req)), or state ∈ {A_ADDR, A_WAIT, B_ADDR, B_WAIT}.
  - 0 in DONE and in an idle IDLE.
  - The core therefore holds its request inputs stable from IDLE through DONE, and advances on the DONE edge.
- Minimum latency: a single access with addr_ok and data_ok each one cycle after they become possible takes IDLE→A_ADDR→A_WAIT→DONE = 4 cycles, with stallreq high for 3 of them.
- At most one bus transaction is outstanding at any time.
- Request inputs changing while state≠IDLE have no effect.

Test Plan:
- Fetch only: inst_req=1, inst_addr=0xBFC0_0000, addr_ok at the first A_ADDR cycle, data_ok 2 cycles later with rdata=0x2408_0001 -> bus_addr=0x1FC0_0000, bus_wr=0, one inst_rvalid pulse, inst_rdata=0x2408_0001, stallreq high exactly 4 cycles.
- Both accesses, DATA_FIRST=1: data read @0x8000_0010 plus fetch @0xBFC0_0004 -> first bus_addr=0x0000_0010, second 0x1FC0_0004; both rvalid pulse together in the single DONE cycle.
- Store: data_wr=1, data_wstrb=4'b0011, data_wdata=0xDEAD_BEEF, data_addr=0x0000_1000 -> bus_wr=1, bus_wstrb=0011, bus_wdata=0xDEAD_BEEF, bus_addr unchanged; data_rvalid pulses.
- Backpressure: bus_addr_ok held low 5 cycles -> bus_req and bus fields stay constant; stallreq stays 1; no rvalid.
- Reset mid-op: resetn low during A_WAIT, then data_ok arrives -> all outputs 0 immediately; the late data_ok is ignored; state returns to IDLE.
- KSEG_MAP=0: address 0xA000_0020 -> bus_addr=0xA000_0020.
